// File: rtl/rgmii_pkg.sv
// Speed encodings and period helpers shared by the RGMII transmit sequencer.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;

  // TX clock period in clk cycles for a given (normalised) speed.
  function automatic logic [31:0] period_sel(input logic [1:0]  speed,
                                             input logic [31:0] p_10m,
                                             input logic [31:0] p_100m);
    logic [31:0] p;
    case (speed)
      SPEED_10M:  p = p_10m;
      SPEED_100M: p = p_100m;
      default:    p = 32'd1;
    endcase
    return p;
  endfunction

  // Both 2'b10 and 2'b11 select gigabit; fold them to one code.
  function automatic logic [1:0] speed_norm(input logic [1:0] speed);
    return speed[1] ? SPEED_1000M : speed;
  endfunction

endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// Period counter, boundary-only speed sampling and DDR TX clock / MAC enable
// generation. Also exposes next-cycle clock halves so data encoding lines up.
module rgmii_tx_clk_gen
  import rgmii_pkg::*;
#(
  parameter int PERIOD_10M  = 50,
  parameter int PERIOD_100M = 5,
  parameter int CNT_W       = $clog2(PERIOD_10M)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_speed,
  output logic       o_mac_clk_en,
  output logic       o_clk_d1,
  output logic       o_clk_d2,
  output logic [1:0] o_speed_active,
  output logic       o_clk_d1_next,
  output logic       o_clk_d2_next,
  output logic       o_gig_next
);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_speed;
  logic             r_first;
  logic             r_mac_clk_en;
  logic             r_clk_d1;
  logic             r_clk_d2;

  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_speed_next;
  logic [31:0]      w_period;
  logic [31:0]      w_period_next;
  logic [31:0]      w_half;
  logic             w_sample;
  logic             w_clk_d1_next;
  logic             w_clk_d2_next;
  logic             w_mac_clk_en_next;

  always_comb begin
    w_period          = period_sel(r_speed, 32'(PERIOD_10M), 32'(PERIOD_100M));
    // Speed may only change on the last cycle of a period, so a TX clock
    // period is never cut short.
    w_sample          = r_first || (32'(r_cnt) == w_period - 32'd1);
    w_speed_next      = w_sample ? speed_norm(i_speed) : r_speed;
    w_cnt_next        = w_sample ? '0 : r_cnt + CNT_W'(1);
    w_period_next     = period_sel(w_speed_next, 32'(PERIOD_10M), 32'(PERIOD_100M));
    // Half-cycle index h = 2*cnt (rising) / 2*cnt+1 (falling); high while h < P.
    w_half            = 32'(w_cnt_next) << 1;
    w_clk_d1_next     = w_half < w_period_next;
    w_clk_d2_next     = (w_half + 32'd1) < w_period_next;
    w_mac_clk_en_next = (32'(w_cnt_next) == w_period_next - 32'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_speed      <= SPEED_10M;
      r_first      <= 1'b1;
      r_mac_clk_en <= 1'b0;
      r_clk_d1     <= 1'b0;
      r_clk_d2     <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_speed      <= w_speed_next;
      r_first      <= 1'b0;
      r_mac_clk_en <= w_mac_clk_en_next;
      r_clk_d1     <= w_clk_d1_next;
      r_clk_d2     <= w_clk_d2_next;
    end
  end

  assign o_mac_clk_en   = r_mac_clk_en;
  assign o_clk_d1       = r_clk_d1;
  assign o_clk_d2       = r_clk_d2;
  assign o_speed_active = r_speed;
  assign o_clk_d1_next  = w_clk_d1_next;
  assign o_clk_d2_next  = w_clk_d2_next;
  assign o_gig_next     = (w_speed_next == SPEED_1000M);

endmodule

// File: rtl/rgmii_tx_ddr_seq.sv
// Speed-adaptive RGMII transmit sequencer: GMII beat capture and DDR encoding.
// Optional frame/byte/error statistics are compiled in with RGMII_TX_STATS_EN.
module rgmii_tx_ddr_seq
  import rgmii_pkg::*;
#(
  parameter int PERIOD_10M  = 50,
  parameter int PERIOD_100M = 5,
  parameter int CNT_W       = $clog2(PERIOD_10M),
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        speed,
  input  logic [7:0]        mac_txd,
  input  logic              mac_tx_en,
  input  logic              mac_tx_er,
  output logic              mac_clk_en,
  output logic              clk_d1,
  output logic              clk_d2,
  output logic [3:0]        txd_d1,
  output logic [3:0]        txd_d2,
  output logic              ctl_d1,
  output logic              ctl_d2,
  output logic [1:0]        speed_active
`ifdef RGMII_TX_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_frames,
  output logic [STAT_W-1:0] stat_bytes,
  output logic [STAT_W-1:0] stat_err_frames
`endif
);

  logic       w_mac_clk_en;
  logic       w_clk_d1_next;
  logic       w_clk_d2_next;
  logic       w_gig_next;
  logic [1:0] w_speed_active;

  rgmii_tx_clk_gen #(
    .PERIOD_10M (PERIOD_10M),
    .PERIOD_100M(PERIOD_100M),
    .CNT_W      (CNT_W)
  ) u_clk_gen (
    .clk           (clk),
    .rst           (rst),
    .i_speed       (speed),
    .o_mac_clk_en  (w_mac_clk_en),
    .o_clk_d1      (clk_d1),
    .o_clk_d2      (clk_d2),
    .o_speed_active(w_speed_active),
    .o_clk_d1_next (w_clk_d1_next),
    .o_clk_d2_next (w_clk_d2_next),
    .o_gig_next    (w_gig_next)
  );

  logic [7:0] r_hold_txd;
  logic       r_hold_en;
  logic       r_hold_er;
  logic [3:0] r_txd_d1;
  logic [3:0] r_txd_d2;
  logic       r_ctl_d1;
  logic       r_ctl_d2;

  logic [7:0] w_txd_next;
  logic       w_en_next;
  logic       w_er_next;

  // Encoding uses the hold value and clock halves of the coming cycle so the
  // freshly captured beat appears together with cnt == 0.
  always_comb begin
    w_txd_next = w_mac_clk_en ? mac_txd   : r_hold_txd;
    w_en_next  = w_mac_clk_en ? mac_tx_en : r_hold_en;
    w_er_next  = w_mac_clk_en ? mac_tx_er : r_hold_er;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_txd <= '0;
      r_hold_en  <= 1'b0;
      r_hold_er  <= 1'b0;
      r_txd_d1   <= '0;
      r_txd_d2   <= '0;
      r_ctl_d1   <= 1'b0;
      r_ctl_d2   <= 1'b0;
    end else begin
      r_hold_txd <= w_txd_next;
      r_hold_en  <= w_en_next;
      r_hold_er  <= w_er_next;
      r_txd_d1   <= w_txd_next[3:0];
      r_txd_d2   <= w_gig_next ? w_txd_next[7:4] : w_txd_next[3:0];
      // RGMII carries en on the high clock half and en^er on the low half.
      r_ctl_d1   <= w_clk_d1_next ? w_en_next : (w_en_next ^ w_er_next);
      r_ctl_d2   <= w_clk_d2_next ? w_en_next : (w_en_next ^ w_er_next);
    end
  end

  assign mac_clk_en   = w_mac_clk_en;
  assign txd_d1       = r_txd_d1;
  assign txd_d2       = r_txd_d2;
  assign ctl_d1       = r_ctl_d1;
  assign ctl_d2       = r_ctl_d2;
  assign speed_active = w_speed_active;

`ifdef RGMII_TX_STATS_EN
  logic [STAT_W-1:0] r_frames;
  logic [STAT_W-1:0] r_bytes;
  logic [STAT_W-1:0] r_err_frames;
  logic              r_prev_en;
  logic              r_nibble;
  logic              r_frame_err;

  logic w_sof;
  logic w_byte_beat;
  logic w_err_hit;

  // At 10/100 a byte is two nibble beats; it counts on the second one.
  always_comb begin
    w_sof       = mac_tx_en && !r_prev_en;
    w_byte_beat = mac_tx_en && ((w_speed_active == SPEED_1000M) || (r_nibble && !w_sof));
    w_err_hit   = mac_tx_en && mac_tx_er && (w_sof || !r_frame_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames     <= '0;
      r_bytes      <= '0;
      r_err_frames <= '0;
      r_prev_en    <= 1'b0;
      r_nibble     <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (w_mac_clk_en) begin
      r_prev_en   <= mac_tx_en;
      r_nibble    <= mac_tx_en && (w_sof || !r_nibble);
      r_frame_err <= mac_tx_en && (mac_tx_er || (r_frame_err && !w_sof));
      if (w_sof && (r_frames != '1))
        r_frames <= r_frames + STAT_W'(1);
      if (w_byte_beat && (r_bytes != '1))
        r_bytes <= r_bytes + STAT_W'(1);
      if (w_err_hit && (r_err_frames != '1))
        r_err_frames <= r_err_frames + STAT_W'(1);
    end
  end

  assign stat_frames     = r_frames;
  assign stat_bytes      = r_bytes;
  assign stat_err_frames = r_err_frames;
`endif

endmodule

// File: tb/tb_rgmii_tx_ddr_seq.sv
// Scoreboard bench for rgmii_tx_ddr_seq: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rgmii_tx_ddr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] mac_txd;
  logic       mac_tx_en;
  logic       mac_tx_er;
  logic       mac_clk_en;
  logic       clk_d1;
  logic       clk_d2;
  logic [3:0] txd_d1;
  logic [3:0] txd_d2;
  logic       ctl_d1;
  logic       ctl_d2;
  logic [1:0] speed_active;
`ifdef RGMII_TX_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_bytes;
  logic [31:0] stat_err_frames;
`endif

  always #4 clk = ~clk;

  rgmii_tx_ddr_seq #(
    .PERIOD_10M (50),
    .PERIOD_100M(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .speed       (speed),
    .mac_txd     (mac_txd),
    .mac_tx_en   (mac_tx_en),
    .mac_tx_er   (mac_tx_er),
    .mac_clk_en  (mac_clk_en),
    .clk_d1      (clk_d1),
    .clk_d2      (clk_d2),
    .txd_d1      (txd_d1),
    .txd_d2      (txd_d2),
    .ctl_d1      (ctl_d1),
    .ctl_d2      (ctl_d2),
    .speed_active(speed_active)
`ifdef RGMII_TX_STATS_EN
    ,
    .stat_frames    (stat_frames),
    .stat_bytes     (stat_bytes),
    .stat_err_frames(stat_err_frames)
`endif
  );

  typedef struct packed {
    logic       cd1;
    logic       cd2;
    logic [3:0] t1;
    logic [3:0] t2;
    logic       k1;
    logic       k2;
    logic       en;
    logic [1:0] sp;
  } vec_t;

  typedef struct {
    int    cyc;
    vec_t  v;
    string name;
  } exp_t;

  exp_t q[$];
`ifdef RGMII_TX_STATS_EN
  typedef struct {
    int          cyc;
    logic [31:0] f;
    logic [31:0] b;
    logic [31:0] e;
  } st_t;
  st_t sq[$];
  st_t se;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   fin = 1'b0;
  vec_t act;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input vec_t v);
    return $sformatf("clk=%b%b txd=%h/%h ctl=%b%b en=%b spd=%b",
                     v.cd1, v.cd2, v.t1, v.t2, v.k1, v.k2, v.en, v.sp);
  endfunction

  always @(negedge clk) begin
    act = {clk_d1, clk_d2, txd_d1, txd_d2, ctl_d1, ctl_d2, mac_clk_en, speed_active};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d got %s want %s", e.name, cyc, fmt(act), fmt(e.v));
      end else begin
        $display("ok   %s cyc=%0d %s", e.name, cyc, fmt(act));
      end
    end
`ifdef RGMII_TX_STATS_EN
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      se = sq.pop_front();
      checks++;
      if (stat_frames !== se.f || stat_bytes !== se.b || stat_err_frames !== se.e) begin
        errors++;
        $display("FAIL stats cyc=%0d got f=%0d b=%0d e=%0d want f=%0d b=%0d e=%0d",
                 cyc, stat_frames, stat_bytes, stat_err_frames, se.f, se.b, se.e);
      end else begin
        $display("ok   stats cyc=%0d f=%0d b=%0d e=%0d", cyc, stat_frames, stat_bytes, stat_err_frames);
      end
    end
`endif
    if (done && !fin) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d want 0", q.size());
      end
      fin = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_push(input int c, input logic cd1, input logic cd2,
                          input logic [3:0] t1, input logic [3:0] t2,
                          input logic k1, input logic k2, input logic en,
                          input logic [1:0] sp, input string nm);
    exp_t x;
    x.cyc  = c;
    x.v    = {cd1, cd2, t1, t2, k1, k2, en, sp};
    x.name = nm;
    q.push_back(x);
  endtask

  // Hand-derived P = 5 clock halves per cnt.
  bit p5_d1 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  bit p5_d2 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c;
    int c1;
    int t0;
    rst = 1'b1; speed = 2'b10; mac_txd = 8'hA5; mac_tx_en = 1'b1; mac_tx_er = 1'b0;

    // Reset state.
    tick(); exp_push(cyc, 0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "reset0");
    tick(); exp_push(cyc, 0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "reset1");
    rst = 1'b0; c = cyc;

    // 1000M: first sample edge has no captured beat yet, then A5 every cycle.
    exp_push(c,     0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "rel_first");
    exp_push(c + 1, 1, 0, 4'h0, 4'h0, 0, 0, 1, 2'b10, "g_first");
    for (int k = 2; k <= 5; k++)
      exp_push(c + k, 1, 0, 4'h5, 4'hA, 1, 1, 1, 2'b10, "g_a5");
    repeat (5) tick();

    // 100M, P = 5: txd 3C, then 7E with er=1 captured at next period boundary.
    c1 = cyc;
    speed = 2'b01; mac_txd = 8'h3C;
    for (int k = 0; k < 5; k++)
      exp_push(c1 + 1 + k, p5_d1[k], p5_d2[k], 4'hC, 4'hC, 1, 1, (k == 4), 2'b01, "m_3c");
    for (int k = 0; k < 5; k++)
      exp_push(c1 + 6 + k, p5_d1[k], p5_d2[k], 4'hE, 4'hE, p5_d1[k], p5_d2[k], (k == 4), 2'b01, "m_7e");
    for (int k = 0; k < 3; k++)
      exp_push(c1 + 11 + k, p5_d1[k], p5_d2[k], 4'hE, 4'hE, p5_d1[k], p5_d2[k], 0, 2'b01, "m_7e_p3");
    repeat (3) tick();
    mac_txd = 8'h7E; mac_tx_er = 1'b1;
    repeat (11) tick();

    // Reset at cnt = 3, release, pattern restarts from cnt = 0 with empty hold.
    rst = 1'b1;
    exp_push(c1 + 14, 0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "rst_mid");
    tick();
    exp_push(c1 + 15, 0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "rst_hold");
    tick();
    rst = 1'b0;
    exp_push(c1 + 16, 0, 0, 4'h0, 4'h0, 0, 0, 0, 2'b00, "rel2_first");
    for (int k = 0; k < 5; k++)
      exp_push(c1 + 17 + k, p5_d1[k], p5_d2[k], 4'h0, 4'h0, 0, 0, (k == 4), 2'b01, "m_post_rst");
    exp_push(c1 + 22, 1, 1, 4'hE, 4'hE, 1, 1, 0, 2'b01, "m_recap");
    exp_push(c1 + 26, 0, 0, 4'hE, 4'hE, 0, 0, 1, 2'b01, "m_last");
    repeat (6) tick();

    // Request 10M mid-period; it takes effect at the boundary after cnt = 4.
    speed = 2'b00; mac_txd = 8'h96; mac_tx_en = 1'b1; mac_tx_er = 1'b1;
    t0 = c1 + 27;
    for (int k = 0; k < 50; k++)
      exp_push(t0 + k, (k < 25), (k < 25), 4'h6, 4'h6, (k < 25), (k < 25), (k == 49), 2'b00, "s10");
    exp_push(t0 + 50, 1, 0, 4'hA, 4'h5, 1, 1, 1, 2'b10, "g_5a");
    exp_push(t0 + 51, 1, 0, 4'hA, 4'h5, 1, 1, 1, 2'b10, "g_5a");
    repeat (15) tick();

    // Switch to 1000M at 10M cnt = 10; the 50-cycle period must complete.
    speed = 2'b10; mac_txd = 8'h5A; mac_tx_er = 1'b0;
    repeat (42) tick();

`ifdef RGMII_TX_STATS_EN
    rst = 1'b1; speed = 2'b10; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mac_tx_en = 1'b1;
    repeat (64) tick();
    mac_tx_en = 1'b0;
    repeat (4) tick();
    mac_tx_en = 1'b1;
    repeat (10) tick();
    mac_tx_er = 1'b1;
    tick();
    mac_tx_er = 1'b0;
    repeat (53) tick();
    mac_tx_en = 1'b0;
    tick();
    se.cyc = cyc; se.f = 32'd2; se.b = 32'd128; se.e = 32'd1;
    sq.push_back(se);
`endif

    repeat (2) tick();
    done = 1'b1;
    wait (fin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
